// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: segment patterns,
// the blank input code and the slot FSM state type.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic {
    SLOT_GAP   = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_t;

  function automatic logic [6:0] digit_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern, with a
// blank override. Non-decimal digit codes also render blank.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : digit_pattern(i_digit);

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit multiplexed display for two countdown lights (q on digits 0/1,
// r on digits 2/3) with frame-coherent snapshots and low-value blinking.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       resetSW,
  input  logic [3:0] q,
  input  logic [3:0] r,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  slot_state_t   r_state;
  logic [3:0]    r_snap_q, r_snap_r;
  logic [FW-1:0] r_frame;
  logic          r_blink_on;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_tick, w_wrap;
  slot_state_t   w_state_nxt;
  logic [3:0]    w_val, w_ones, w_digit;
  logic          w_tens_one, w_blank;
  logic [6:0]    w_seg_dec;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;

  assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_wrap = w_tick && (r_idx == 2'd3);

  // NOTE: every register here, including the snapshots, is in the async
  // reset so the display goes dark the instant resetSW rises.
  always_ff @(posedge clk or posedge resetSW) begin
    if (resetSW) begin
      r_presc    <= '0;
      r_idx      <= 2'd0;
      r_snap_q   <= BLANK_CODE;
      r_snap_r   <= BLANK_CODE;
      r_frame    <= '0;
      r_blink_on <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
      if (w_wrap) begin
        r_snap_q <= q;
        r_snap_r <= r;
        if (r_frame == FW'(BLINK_FRAMES - 1)) begin
          r_frame    <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_frame <= r_frame + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge resetSW) begin
    if (resetSW) r_state <= SLOT_GAP;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_val      = r_idx[1] ? r_snap_r : r_snap_q;
    w_tens_one = (w_val >= 4'd10);
    w_ones     = w_tens_one ? (w_val - 4'd10) : w_val;
    w_digit    = r_idx[0] ? {3'b000, w_tens_one} : w_ones;
    w_blank    = (w_val == BLANK_CODE)
              || (r_idx[0] && !w_tens_one)
              || (!r_blink_on && (w_val <= 4'd5));
  end

  bcd_to_seg7 u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg_dec)
  );

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_an_nxt    = 4'hF;
    w_seg_nxt   = SEG_BLANK;
    case (r_state)
      SLOT_GAP:   w_state_nxt = SLOT_DRIVE;
      SLOT_DRIVE: w_state_nxt = SLOT_DRIVE;
    endcase
    if (w_tick) w_state_nxt = SLOT_GAP;
    // Index and snapshots only move on a tick, which forces GAP, so decoding
    // the current registers is correct for the DRIVE cycle being loaded.
    if (w_state_nxt == SLOT_DRIVE) begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = w_seg_dec;
    end
  end

  always_ff @(posedge clk or posedge resetSW) begin
    if (resetSW) begin
      r_an  <= 4'hF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (minimum 4).
REQ-002 SHALL have parameter BLINK_FRAMES, default 125, meaning frames per blink half-period (minimum 1).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetSW, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port q, input, 4, light-A countdown value; 4'hF means inactive/blank.
REQ-006 SHALL have port r, input, 4, light-B countdown value; 4'hF means inactive/blank.
REQ-007 SHALL have port seg, output, 7, cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 SHALL have port an, output, 4, digit anodes, active-low, registered.
REQ-009 SHALL have port dp, output, 1, decimal point, active-low, held 1 (off) at all times.

Function
REQ-010 SHALL run a prescaler counting 0..REFRESH_DIV-1, wrapping to 0, and assert an internal one-cycle tick at terminal count.
REQ-011 SHALL advance the digit index 0->1->2->3->0 on each tick.
REQ-012 SHALL map the digit index as: 0 = q ones, 1 = q tens, 2 = r ones, 3 = r tens, with anode an[index].
REQ-013 SHALL capture q and r into snapshot registers only on the tick where the index wraps 3->0; the frame that starts on that tick SHALL use the new snapshot (latency <= 4*REFRESH_DIV cycles).
REQ-014 SHALL display snapshot values 0..14 in decimal: ones = value mod 10, tens = value div 10.
REQ-015 SHALL blank a tens digit that is 0 (leading-zero suppression); value 0 SHALL show "0" on the ones digit only.
REQ-016 SHALL blank both digits of a light whose snapshot is 4'hF.
REQ-017 SHALL implement a two-state slot FSM: GAP (an = 4'hF, seg = 7'h7F) lasting exactly one cycle after each tick, then DRIVE (selected anode low, decoded segments) for the rest of the slot.
REQ-018 SHALL keep a frame counter 0..BLINK_FRAMES-1, incremented on each 3->0 wrap, toggling a blink phase at terminal count.
REQ-019 SHALL, while blink phase = off, blank the digits of any light whose snapshot is 0..5; lights with snapshot 6..14 or 4'hF SHALL be unaffected by blink.
REQ-020 SHALL, in DRIVE, drive a blanked digit as seg = 7'h7F with its anode still low.
REQ-021 SHALL produce at most one anode low in any cycle.
REQ-022 SHALL ignore q/r changes between frame boundaries, including changes coincident with non-wrap ticks.

Reset
REQ-023 SHALL, on resetSW high, asynchronously set prescaler = 0, index = 0, slot FSM = GAP, snapshots = 4'hF, frame counter = 0, blink phase = on, an = 4'hF, seg = 7'h7F, dp = 1.
REQ-024 SHALL, on resetSW release, resume counting from prescaler 0 on the next clk edge; reset mid-slot SHALL discard the slot in progress.

Structure
REQ-025 SHALL place segment patterns for 0..9 and SEG_BLANK (7'h7F), and the BLANK_CODE constant 4'hF, in shared package seg_pkg.
REQ-026 SHALL use one combinational sub-module bcd_to_seg7 (4-bit digit plus blank flag in, 7-bit active-low pattern out).
REQ-027 SHALL contain no derived or gated clocks; prescaler tick is a clock enable only.

Verification (bench: REFRESH_DIV = 4, BLINK_FRAMES = 2)
REQ-028 SHALL check reset: assert resetSW mid-slot -> an = 4'hF, seg = 7'h7F, dp = 1 immediately, no clk edge needed.
REQ-029 SHALL check scan: q = 12, r = 7 held -> after first wrap, slots show an = 1110/"2", 1101/"1", 1011/"7", 0111/blank, each slot preceded by one GAP cycle.
REQ-030 SHALL check blanking: q = 4'hF, r = 9 -> an[0], an[1] slots show seg = 7'h7F; r ones shows "9", r tens blank.
REQ-031 SHALL check snapshot coherence: change q from 12 to 8 during slot 1 -> remainder of frame still shows 12; next frame shows "8".
REQ-032 SHALL check blink: q = 3, r = 10 -> q digits alternate visible/blank every 2 frames; r digits always show "0" and "1".
REQ-033 SHALL check one-hot anodes: random q/r over 1000 frames -> an never has more than one 0 bit.
